wb_b3_sram_slave: RTL and testbench

- Wishbone B3 registered-feedback SRAM slave that sits directly downstream of the three-master RAM arbiter.
- Consumes the arbiter's muxed single-master bus and implements a byte-addressed, word-wide synchronous memory.
- Supports classic cycles and incrementing bursts in linear, wrap4, wrap8 and wrap16 modes.
- Sustains one ack per clock during bursts, so bursts are not throttled at the arbiter's output.

---
 rtl/wb_b3_sram_slave_pkg.sv | 23 ++
 rtl/wb_b3_sram_slave_if.sv | 36 +++
 rtl/wb_b3_sram_slave_burst_adr_gen.sv | 45 ++++
 rtl/wb_b3_sram_slave.sv | 146 ++++++++++++++
 tb/tb_wb_b3_sram_slave.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_b3_sram_slave_pkg.sv
// wb_b3_pkg: shared Wishbone B3 encodings for the SRAM slave and its
// burst address generator.
//   CTI_*   cycle type identifiers
//   BTE_*   burst type extensions
//   state_e slave FSM state encoding
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LIN    = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/wb_b3_sram_slave_if.sv
// wb_b3_sram_slave_if: Wishbone B3 single-master bus bundle.
// Signal names are from the slave's point of view.
//   wb_adr_i/bte_i/cti_i/cyc_i/stb_i/we_i/sel_i/dat_i  master -> slave
//   wb_ack_o/err_o/rty_o/dat_o                          slave -> master
// Modports: slave (used by wb_b3_sram_slave), master (used by a bus driver).
interface wb_b3_sram_slave_if #(
  parameter int aw = 32,
  parameter int dw = 32
) ();

  logic [aw-1:0]   wb_adr_i;
  logic [1:0]      wb_bte_i;
  logic [2:0]      wb_cti_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_we_i;
  logic [dw/8-1:0] wb_sel_i;
  logic [dw-1:0]   wb_dat_i;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;
  logic [dw-1:0]   wb_dat_o;

  modport slave (
    input  wb_adr_i, wb_bte_i, wb_cti_i, wb_cyc_i, wb_stb_i, wb_we_i,
           wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

  modport master (
    output wb_adr_i, wb_bte_i, wb_cti_i, wb_cyc_i, wb_stb_i, wb_we_i,
           wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

endinterface

// File: rtl/wb_b3_sram_slave_burst_adr_gen.sv
// wb_b3_burst_adr_gen: combinational next-beat address for B3 incrementing
// bursts. Reusable by any word-wide B3 slave.
//   adr_i      current byte address
//   bte_i      burst type (linear / wrap4 / wrap8 / wrap16)
//   adr_nxt_o  byte address of the following beat
// Linear mode carries into the upper bits so a slave with range checking
// can see the crossing; a slave that ignores the upper bits sees it wrap.
// Wrap windows are clipped to the memory size for very small memories.
module wb_b3_burst_adr_gen
  import wb_b3_pkg::*;
#(
  parameter int aw            = 32,
  parameter int mem_adr_width = 10
) (
  input  logic [aw-1:0] adr_i,
  input  logic [1:0]    bte_i,
  output logic [aw-1:0] adr_nxt_o
);

  localparam int IW = mem_adr_width - 2;

  // Mask covering the byte-offset bits plus the wrapping word-index bits.
  function automatic logic [aw-1:0] wrap_mask(input int bits);
    int n;
    n = (bits < IW) ? bits : IW;
    return (aw'(1) << (n + 2)) - aw'(1);
  endfunction

  logic [aw-1:0] inc;
  logic [aw-1:0] mask;

  always_comb begin
    inc  = adr_i + aw'(4);
    mask = '1;
    case (bte_i)
      BTE_LIN:    mask = '1;
      BTE_WRAP4:  mask = wrap_mask(2);
      BTE_WRAP8:  mask = wrap_mask(3);
      BTE_WRAP16: mask = wrap_mask(4);
      default:    mask = '1;
    endcase
    adr_nxt_o = (inc & mask) | (adr_i & ~mask);
  end

endmodule

// File: rtl/wb_b3_sram_slave.sv
// wb_b3_sram_slave: Wishbone B3 registered-feedback SRAM slave.
// Byte-addressed, word-wide synchronous memory; classic cycles take one
// wait state, incrementing bursts stream one ack per clock.
//   wb_clk_i  clock
//   wb_rst_i  asynchronous active-high reset
//   wb        wb_b3_sram_slave_if.slave bus bundle
// Build option: define WB_B3_SRAM_ADR_ERR_EN to answer beats addressed at or
// beyond mem_size_bytes with wb_err_o instead of aliasing into the memory.
//
// state | meaning
// IDLE  | no burst in progress; classic beats and burst first beats start here
// BURST | incrementing burst streaming, ack held high between beats
module wb_b3_sram_slave
  import wb_b3_pkg::*;
#(
  parameter int          dw             = 32,
  parameter int          aw             = 32,
  parameter logic [31:0] mem_size_bytes = 32'h0000_0400,
  parameter int          mem_adr_width  = 10
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  wb_b3_sram_slave_if.slave wb
);

  localparam int IW        = mem_adr_width - 2;
  localparam int MEM_WORDS = int'(mem_size_bytes >> 2);

  function automatic logic [IW-1:0] word_idx(input logic [aw-1:0] a);
    return a[mem_adr_width-1:2];
  endfunction

  logic [dw-1:0] mem_q [MEM_WORDS];

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [dw-1:0] dat_q, dat_d;
  logic [aw-1:0] adr_nxt;
  logic          bus_act;
  logic          beat;
  logic          start_oor;
  logic          nxt_oor;

  wb_b3_burst_adr_gen #(
    .aw            (aw),
    .mem_adr_width (mem_adr_width)
  ) u_adr_gen (
    .adr_i     (adr_q),
    .bte_i     (wb.wb_bte_i),
    .adr_nxt_o (adr_nxt)
  );

  assign bus_act = wb.wb_cyc_i & wb.wb_stb_i;
  assign beat    = ack_q & bus_act;

`ifdef WB_B3_SRAM_ADR_ERR_EN
  assign start_oor = |wb.wb_adr_i[aw-1:mem_adr_width];
  assign nxt_oor   = |adr_nxt[aw-1:mem_adr_width];
`else
  assign start_oor = 1'b0;
  assign nxt_oor   = 1'b0;
`endif

  assign wb.wb_ack_o = beat;
  assign wb.wb_err_o = err_q & bus_act;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = dat_q;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        // A just-finished ack or error blocks a new start for one cycle.
        if (bus_act && !ack_q && !err_q) begin
          adr_d = wb.wb_adr_i;
          if (start_oor) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            dat_d = mem_q[word_idx(wb.wb_adr_i)];
            if (wb.wb_cti_i == CTI_INC) state_d = BURST;
          end
        end else begin
          ack_d = 1'b0;
        end
      end
      BURST: begin
        if (!wb.wb_cyc_i) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else if (beat) begin
          if (wb.wb_cti_i == CTI_EOB) begin
            ack_d   = 1'b0;
            state_d = IDLE;
          end else begin
            adr_d = adr_nxt;
            if (nxt_oor) begin
              ack_d   = 1'b0;
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              dat_d = mem_q[word_idx(adr_nxt)];
            end
          end
        end
        // stb low with cyc high: master wait state, everything holds.
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  // Memory is not reset; ack_q is cleared by reset so no write slips through.
  always_ff @(posedge wb_clk_i) begin
    if (beat && wb.wb_we_i) begin
      for (int i = 0; i < dw/8; i++) begin
        if (wb.wb_sel_i[i]) mem_q[word_idx(adr_q)][8*i +: 8] <= wb.wb_dat_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_b3_sram_slave.sv
module tb_wb_b3_sram_slave;
  import wb_b3_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_b3_sram_slave_if bus ();

  wb_b3_sram_slave dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cti_i = CTI_CLASSIC;
    bus.wb_bte_i = BTE_LIN;
    bus.wb_sel_i = 4'h0;
    bus.wb_dat_i = '0;
    bus.wb_adr_i = '0;
  endtask

  task automatic classic_wr(input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, output logic ack);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = adr;  bus.wb_sel_i = sel;  bus.wb_dat_i = dat;
    bus.wb_cti_i = CTI_CLASSIC;
    step();
    ack = bus.wb_ack_o;
    step();
    idle_bus();
    step();
  endtask

  task automatic classic_rd(input logic [31:0] adr, output logic ack,
                            output logic err, output logic [31:0] dat);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = adr;  bus.wb_sel_i = 4'hF;
    bus.wb_cti_i = CTI_CLASSIC;
    step();
    ack = bus.wb_ack_o;
    err = bus.wb_err_o;
    dat = bus.wb_dat_o;
    step();
    idle_bus();
    step();
  endtask

  // Two-beat incrementing read burst; reports both beats.
  task automatic burst_rd2(input logic [31:0] adr, input logic [1:0] bte,
                           output logic a0, output logic [31:0] d0,
                           output logic a1, output logic e1, output logic [31:0] d1);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = adr;  bus.wb_bte_i = bte;  bus.wb_cti_i = CTI_INC;
    step();
    a0 = bus.wb_ack_o;
    d0 = bus.wb_dat_o;
    step();
    a1 = bus.wb_ack_o;
    e1 = bus.wb_err_o;
    d1 = bus.wb_dat_o;
    bus.wb_cti_i = CTI_EOB;
    step();
    idle_bus();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        a, e, a0, a1, e1;
    logic [31:0] d, d0, d1;
    logic [31:0] exp2 [4];

    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", bus.wb_ack_o, 0);
    chk("rst_err", bus.wb_err_o, 0);
    chk("rst_rty", bus.wb_rty_o, 0);
    chk("rst_dat", bus.wb_dat_o, 32'h0);
    rst = 1'b0;
    step();

    // 1: classic write then back-to-back classic read of 0x10
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 32'h10; bus.wb_sel_i = 4'hF; bus.wb_dat_i = 32'hDEAD_BEEF;
    bus.wb_cti_i = CTI_CLASSIC;
    step();
    chk("t1_wr_ack", bus.wb_ack_o, 1);
    step();
    chk("t1_wr_gap", bus.wb_ack_o, 0);
    bus.wb_we_i = 1'b0; bus.wb_dat_i = '0;
    step();
    chk("t1_rd_ack", bus.wb_ack_o, 1);
    chk("t1_rd_dat", bus.wb_dat_o, 32'hDEAD_BEEF);
    step();
    chk("t1_rd_gap", bus.wb_ack_o, 0);
    idle_bus();
    step();

    // 2: byte-lane write
    classic_wr(32'h10, 4'b0010, 32'h0000_AA00, a);
    chk("t2_wr_ack", a, 1);
    classic_rd(32'h10, a, e, d);
    chk("t2_rd_dat", d, 32'hDEAD_AAEF);

    // preload
    for (int i = 0; i < 4; i++) begin
      classic_wr(32'h20 + 32'(4*i), 4'hF, 32'hC0DE_0008 + 32'(i), a);
    end
    classic_wr(32'h40, 4'hF, 32'h5555_AAAA, a);
    classic_wr(32'h0, 4'hF, 32'h0BAD_F00D, a);
    classic_wr(32'h3FC, 4'hF, 32'hFFEE_0255, a);
    chk("pre_ack", a, 1);

    // 3: linear 4-beat read burst from 0x20
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h20; bus.wb_bte_i = BTE_LIN; bus.wb_cti_i = CTI_INC;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t3_ack%0d", k), bus.wb_ack_o, 1);
      chk($sformatf("t3_dat%0d", k), bus.wb_dat_o, 32'hC0DE_0008 + 32'(k));
      if (k == 3) bus.wb_cti_i = CTI_EOB;
    end
    step();
    chk("t3_idle_ack", bus.wb_ack_o, 0);
    idle_bus();
    step();

    // 4: wrap4 write burst from 0x38 (words 14,15,12,13)
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_sel_i = 4'hF; bus.wb_adr_i = 32'h38;
    bus.wb_bte_i = BTE_WRAP4; bus.wb_cti_i = CTI_INC;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t4_ack%0d", k), bus.wb_ack_o, 1);
      bus.wb_dat_i = 32'h4000_00A0 + 32'(k);
      if (k == 3) bus.wb_cti_i = CTI_EOB;
    end
    step();
    idle_bus();
    step();
    classic_rd(32'h30, a, e, d); chk("t4_w12", d, 32'h4000_00A2);
    classic_rd(32'h34, a, e, d); chk("t4_w13", d, 32'h4000_00A3);
    classic_rd(32'h38, a, e, d); chk("t4_w14", d, 32'h4000_00A0);
    classic_rd(32'h3C, a, e, d); chk("t4_w15", d, 32'h4000_00A1);
    classic_rd(32'h40, a, e, d); chk("t4_w16", d, 32'h5555_AAAA);

    // 5: master wait state of 2 cycles after beat 2
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h20; bus.wb_bte_i = BTE_LIN; bus.wb_cti_i = CTI_INC;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5_ack%0d", k), bus.wb_ack_o, 1);
      chk($sformatf("t5_dat%0d", k), bus.wb_dat_o, 32'hC0DE_0008 + 32'(k));
    end
    step();
    bus.wb_stb_i = 1'b0;
    #1;
    chk("t5_gap0_ack", bus.wb_ack_o, 0);
    step();
    chk("t5_gap1_ack", bus.wb_ack_o, 0);
    chk("t5_gap_dat", bus.wb_dat_o, 32'hC0DE_000B);
    step();
    bus.wb_stb_i = 1'b1; bus.wb_cti_i = CTI_EOB;
    #1;
    chk("t5_resume_ack", bus.wb_ack_o, 1);
    chk("t5_resume_dat", bus.wb_dat_o, 32'hC0DE_000B);
    step();
    chk("t5_end_ack", bus.wb_ack_o, 0);
    idle_bus();
    step();

    // burst types from word 15: second beat word
    exp2[0] = 32'h5555_AAAA;  // linear -> 16
    exp2[1] = 32'h4000_00A2;  // wrap4  -> 12
    exp2[2] = 32'hC0DE_0008;  // wrap8  -> 8
    exp2[3] = 32'h0BAD_F00D;  // wrap16 -> 0
    for (int b = 0; b < 4; b++) begin
      burst_rd2(32'h3C, 2'(b), a0, d0, a1, e1, d1);
      chk($sformatf("bte%0d_d0", b), d0, 32'h4000_00A1);
      chk($sformatf("bte%0d_a1", b), a1, 1);
      chk($sformatf("bte%0d_d1", b), d1, exp2[b]);
    end

    // linear burst across the top of memory, and out-of-range classic read
    burst_rd2(32'h3FC, BTE_LIN, a0, d0, a1, e1, d1);
    chk("top_a0", a0, 1);
    chk("top_d0", d0, 32'hFFEE_0255);
    classic_rd(32'h400, a, e, d);
`ifdef WB_B3_SRAM_ADR_ERR_EN
    chk("top_a1", a1, 0);
    chk("top_e1", e1, 1);
    chk("oor_ack", a, 0);
    chk("oor_err", e, 1);
`else
    chk("top_a1", a1, 1);
    chk("top_e1", e1, 0);
    chk("top_d1", d1, 32'h0BAD_F00D);
    chk("oor_ack", a, 1);
    chk("oor_err", e, 0);
    chk("oor_dat", d, 32'h0BAD_F00D);
`endif

    // 6: async reset mid-burst
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h20; bus.wb_bte_i = BTE_LIN; bus.wb_cti_i = CTI_INC;
    step();
    step();
    chk("rb_pre_dat", bus.wb_dat_o, 32'hC0DE_0009);
    rst = 1'b1;
    #1;
    chk("rb_ack_drop", bus.wb_ack_o, 0);
    chk("rb_dat_clr", bus.wb_dat_o, 32'h0);
    #2;
    rst = 1'b0;
    bus.wb_adr_i = 32'h24; bus.wb_cti_i = CTI_CLASSIC;
    step();
    chk("rb_idle_ack", bus.wb_ack_o, 1);
    chk("rb_idle_dat", bus.wb_dat_o, 32'hC0DE_0009);
    step();
    chk("rb_classic_gap", bus.wb_ack_o, 0);
    idle_bus();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
